// File: rtl/logic_accum.sv
// logic_accum: bitwise logic unit with an optional accumulate mode.
// A beat either produces a single-shot result f(x,y), or starts a sequence
// that folds later x operands into a running value with the op latched
// from the first beat. The result is held with out_valid until it is consumed.
// Optional feature: define LOGIC_ACCUM_PARITY_EN to add a 'parity' output
// that carries the XOR-reduction of oout.
module logic_accum #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       op,
    input  logic             acc_mode,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] oout,
    output logic [CNT_W-1:0] beats,
`ifdef LOGIC_ACCUM_PARITY_EN
    output logic             parity,
`endif
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] BEATS_MAX = '1;
    localparam logic [CNT_W-1:0] BEATS_ONE = CNT_W'(1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] acc;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] beat_cnt;
    logic             accept;

    // Bitwise operator; NOR is applied step by step, never regrouped.
    function automatic logic [WIDTH-1:0] apply_op(input logic [1:0]       sel,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (sel)
            2'b00:   r = a | b;
            2'b01:   r = a & b;
            2'b10:   r = a ^ b;
            default: r = ~(a | b);
        endcase
        return r;
    endfunction

    assign accept = in_valid & in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: single-shot or last beat goes straight to HOLD.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!acc_mode || last) begin
                        next_state = HOLD;
                    end else begin
                        next_state = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept && last) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state alone.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state)
            HOLD:    begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath: first beat seeds from x,y; later beats fold x with the latched op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            op_q     <= 2'b00;
            beat_cnt <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                acc      <= apply_op(op, x, y);
                beat_cnt <= BEATS_ONE;
                if (acc_mode) begin
                    op_q <= op;
                end
            end else begin
                acc <= apply_op(op_q, acc, x);
                if (beat_cnt != BEATS_MAX) begin
                    beat_cnt <= beat_cnt + BEATS_ONE;
                end
            end
        end
    end

    assign oout  = acc;
    assign beats = beat_cnt;
    assign zero  = (acc == '0);

`ifdef LOGIC_ACCUM_PARITY_EN
    assign parity = ^acc;
`endif

endmodule

// File: tb/tb_logic_accum.sv
// tb_logic_accum: directed and randomized checks of logic_accum (WIDTH=4, CNT_W=2).
module tb_logic_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] op;
    logic       acc_mode;
    logic       last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] oout;
    logic [1:0] beats;
    logic       zero;
`ifdef LOGIC_ACCUM_PARITY_EN
    logic       parity;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] xs[$];

    logic [3:0] exp_oout;
    int         exp_beats;
    logic       mode;
    int         len;
    logic [3:0] y0;
    logic [1:0] op0;

    logic_accum #(.WIDTH(4), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .op        (op),
        .acc_mode  (acc_mode),
        .last      (last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .oout      (oout),
        .beats     (beats),
`ifdef LOGIC_ACCUM_PARITY_EN
        .parity    (parity),
`endif
        .zero      (zero)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Reference operator taken straight from the op table.
    function automatic logic [3:0] ref_op(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
        case (o)
            2'd0:    return a | b;
            2'd1:    return a & b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Expected result of a whole sequence: seed with f(x0,y0), then fold each later x.
    function automatic logic [3:0] ref_fold(input logic [1:0] o, input logic [3:0] yy);
        logic [3:0] r;
        r = ref_op(o, xs[0], yy);
        for (int i = 1; i < xs.size(); i++) r = ref_op(o, r, xs[i]);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offer one beat at a falling edge; it transfers on the next rising edge.
    task automatic applyStimulus(input logic [3:0] bx, input logic [3:0] by, input logic [1:0] bop,
                                 input logic bmode, input logic blast);
        checkOutput("in_ready_before_beat", in_ready, 1);
        in_valid = 1'b1;
        x        = bx;
        y        = by;
        op       = bop;
        acc_mode = bmode;
        last     = blast;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x        = 4'($urandom);
        y        = 4'($urandom);
        op       = 2'($urandom);
    endtask

    // Idle cycles inside an accumulate sequence; nothing should surface.
    task automatic idleGap(input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checkOutput("gap_out_valid", out_valid, 0);
            checkOutput("gap_in_ready", in_ready, 1);
        end
    endtask

    // Check the held result, stall it for 'hold' cycles, then consume it.
    task automatic drainResult(input string tag, input logic [3:0] e_oout, input int e_beats,
                               input int hold, input logic poke);
        checkOutput({tag, ":out_valid"}, out_valid, 1);
        checkOutput({tag, ":oout"}, oout, e_oout);
        checkOutput({tag, ":beats"}, beats, e_beats);
        checkOutput({tag, ":zero"}, zero, (e_oout == 4'd0));
`ifdef LOGIC_ACCUM_PARITY_EN
        checkOutput({tag, ":parity"}, parity, ^e_oout);
`endif
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            in_valid  = poke;
            x         = 4'($urandom);
            y         = 4'($urandom);
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, ":hold_out_valid"}, out_valid, 1);
            checkOutput({tag, ":hold_in_ready"}, in_ready, 0);
            checkOutput({tag, ":hold_oout"}, oout, e_oout);
            checkOutput({tag, ":hold_beats"}, beats, e_beats);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, ":after_out_valid"}, out_valid, 0);
        checkOutput({tag, ":after_in_ready"}, in_ready, 1);
    endtask

    // Directed steps followed by randomized sequences.
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        x         = 4'b1111;
        y         = 4'b1111;
        op        = 2'b00;
        acc_mode  = 1'b0;
        last      = 1'b1;
        out_ready = 1'b0;

        // Reset with in_valid asserted must be ignored.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst:out_valid", out_valid, 0);
        checkOutput("rst:in_ready", in_ready, 1);
        checkOutput("rst:oout", oout, 0);
        checkOutput("rst:beats", beats, 0);
        checkOutput("rst:zero", zero, 1);
`ifdef LOGIC_ACCUM_PARITY_EN
        checkOutput("rst:parity", parity, 0);
`endif
        rst_n    = 1'b1;
        in_valid = 1'b0;

        $display("[TB] single-shot OR");
        applyStimulus(4'b1010, 4'b0110, 2'b00, 1'b0, 1'b0);
        drainResult("single_or", 4'b1110, 1, 0, 1'b0);

        $display("[TB] accumulate AND with op change mid-sequence");
        applyStimulus(4'b1111, 4'b1101, 2'b01, 1'b1, 1'b0);
        applyStimulus(4'b0111, 4'b0000, 2'b10, 1'b1, 1'b0);
        applyStimulus(4'b0101, 4'b1111, 2'b10, 1'b0, 1'b1);
        drainResult("acc_and", 4'b0101, 3, 0, 1'b0);

        $display("[TB] backpressure for 5 cycles");
        applyStimulus(4'b1011, 4'b0000, 2'b00, 1'b0, 1'b1);
        drainResult("backpressure", 4'b1011, 1, 5, 1'b1);

        $display("[TB] beat counter saturation");
        applyStimulus(4'b0001, 4'b0000, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(4'b0001, 4'b1111, 2'b11, 1'b1, 1'b0);
        applyStimulus(4'b0001, 4'b1111, 2'b11, 1'b1, 1'b1);
        drainResult("saturate", 4'b0001, 3, 0, 1'b0);

        $display("[TB] reset in the middle of a sequence");
        applyStimulus(4'b1100, 4'b0011, 2'b10, 1'b1, 1'b0);
        applyStimulus(4'b0110, 4'b0000, 2'b10, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_accum:out_valid", out_valid, 0);
        checkOutput("rst_accum:oout", oout, 0);
        checkOutput("rst_accum:beats", beats, 0);
        checkOutput("rst_accum:zero", zero, 1);
        rst_n = 1'b1;
        applyStimulus(4'b1000, 4'b0000, 2'b10, 1'b1, 1'b1);
        drainResult("after_rst", 4'b1000, 1, 0, 1'b0);

        $display("[TB] reset while holding a result");
        applyStimulus(4'b0011, 4'b0101, 2'b11, 1'b0, 1'b1);
        checkOutput("rst_hold:pre_out_valid", out_valid, 1);
        rst_n     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_hold:out_valid", out_valid, 0);
        checkOutput("rst_hold:oout", oout, 0);
        rst_n     = 1'b1;
        out_ready = 1'b0;

        $display("[TB] randomized sequences");
        for (int s = 0; s < 40; s++) begin
            mode = 1'($urandom_range(0, 1));
            len  = mode ? $urandom_range(1, 7) : 1;
            op0  = 2'($urandom);
            y0   = 4'($urandom);
            xs.delete();
            for (int i = 0; i < len; i++) xs.push_back(4'($urandom));
            for (int i = 0; i < len; i++) begin
                applyStimulus(xs[i],
                              (i == 0) ? y0 : 4'($urandom),
                              (i == 0) ? op0 : 2'($urandom),
                              (i == 0) ? mode : 1'($urandom),
                              mode ? (i == len - 1) : 1'($urandom));
                if (mode && i < len - 1 && $urandom_range(0, 2) == 0) idleGap($urandom_range(1, 3));
            end
            exp_oout  = ref_fold(op0, y0);
            exp_beats = (len > 3) ? 3 : len;
            drainResult("random", exp_oout, exp_beats, $urandom_range(0, 2), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
